// File: rtl/pwm_fade_pkg.sv
// Shared types and constants for the multi-channel PWM fade driver.
// Provides the 2-bit channel mode type and the four mode encodings.
package pwm_fade_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'd0;
    localparam mode_t MODE_FADE    = 2'd1;
    localparam mode_t MODE_STEADY  = 2'd2;
    localparam mode_t MODE_BREATHE = 2'd3;

endpackage

// File: rtl/pwm_fade_channel.sv
// One LED channel: fade/breathe counter, mode register, level select, drive reg.
// Ports: i_clk, i_rst_n, i_trigger, i_mode, i_pwm_cnt, i_steady_level -> o_drive, o_active.
module pwm_fade_channel
    import pwm_fade_pkg::*;
#(
    parameter int LEVEL_BITS = 8,
    parameter int FADE_BITS  = 27
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_trigger,
    input  mode_t                 i_mode,
    input  logic [LEVEL_BITS-1:0] i_pwm_cnt,
    input  logic [LEVEL_BITS-1:0] i_steady_level,
    output logic                  o_drive,
    output logic                  o_active
);

    localparam logic [FADE_BITS-1:0] FADE_MAX = '1;
    localparam logic [FADE_BITS-1:0] FADE_ONE = FADE_BITS'(1);

    logic [FADE_BITS-1:0]  r_fade_cnt;
    logic                  r_dir;
    mode_t                 r_mode_q;
    logic                  r_drive;

    logic [FADE_BITS-1:0]  w_fade_nxt;
    logic                  w_dir_nxt;
    mode_t                 w_mode_nxt;
    logic                  w_up;
    logic [LEVEL_BITS-1:0] w_level;
    logic                  w_drive_nxt;

    // Breathe direction: turn around at the rails so the counter never wraps.
    assign w_up = r_dir ? (r_fade_cnt != FADE_MAX) : (r_fade_cnt == '0);

    always_comb begin
        w_fade_nxt = r_fade_cnt;
        w_dir_nxt  = r_dir;
        w_mode_nxt = r_mode_q;
        if (i_mode != r_mode_q) begin
            // Mode change wins over trigger and restarts from zero, counting up.
            w_fade_nxt = '0;
            w_dir_nxt  = 1'b1;
            w_mode_nxt = i_mode;
        end else begin
            unique case (r_mode_q)
                MODE_FADE: begin
                    if (i_trigger)
                        w_fade_nxt = FADE_MAX;
                    else if (r_fade_cnt != '0)
                        w_fade_nxt = r_fade_cnt - FADE_ONE;
                end
                MODE_BREATHE: begin
                    if (i_trigger) begin
                        w_fade_nxt = FADE_MAX;
                        w_dir_nxt  = 1'b0;
                    end else if (w_up) begin
                        w_fade_nxt = r_fade_cnt + FADE_ONE;
                        w_dir_nxt  = (w_fade_nxt != FADE_MAX);
                    end else begin
                        w_fade_nxt = r_fade_cnt - FADE_ONE;
                        w_dir_nxt  = (w_fade_nxt == '0);
                    end
                end
                MODE_OFF,
                MODE_STEADY: begin
                    w_fade_nxt = '0;
                end
            endcase
        end
    end

    assign w_level = (r_mode_q == MODE_STEADY)
                   ? i_steady_level
                   : r_fade_cnt[FADE_BITS-1 -: LEVEL_BITS];

    // Max level forces a constant high instead of a 255/256-style duty.
    assign w_drive_nxt = (&w_level) | (i_pwm_cnt < w_level);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fade_cnt <= '0;
            r_dir      <= 1'b1;
            r_mode_q   <= MODE_OFF;
            r_drive    <= 1'b0;
        end else begin
            r_fade_cnt <= w_fade_nxt;
            r_dir      <= w_dir_nxt;
            r_mode_q   <= w_mode_nxt;
            r_drive    <= w_drive_nxt;
        end
    end

    assign o_drive  = r_drive;
    assign o_active = |r_fade_cnt;

endmodule

// File: rtl/pwm_fade_multi.sv
// Multi-channel PWM LED driver sharing one free-running PWM timebase.
// Ports: clk, rst_n, trigger, mode, steady_level -> drive, active (per channel).
module pwm_fade_multi
    import pwm_fade_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int LEVEL_BITS = 8,
    parameter int FADE_BITS  = 27
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   trigger,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [LEVEL_BITS-1:0] steady_level,
    output logic [CHANNELS-1:0]   drive,
    output logic [CHANNELS-1:0]   active
);

    localparam logic [LEVEL_BITS-1:0] PWM_ONE = LEVEL_BITS'(1);

    logic [LEVEL_BITS-1:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pwm_cnt <= '0;
        else
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_fade_channel #(
            .LEVEL_BITS (LEVEL_BITS),
            .FADE_BITS  (FADE_BITS)
        ) u_ch (
            .i_clk          (clk),
            .i_rst_n        (rst_n),
            .i_trigger      (trigger[g]),
            .i_mode         (mode_t'(mode[2*g +: 2])),
            .i_pwm_cnt      (r_pwm_cnt),
            .i_steady_level (steady_level),
            .o_drive        (drive[g]),
            .o_active       (active[g])
        );
    end

endmodule

// File: tb/tb_pwm_fade_multi.sv
// Bench for pwm_fade_multi: directed and random steps against a phase-based model.
// Ports driven: clk, rst_n, trigger, mode, steady_level; observed: drive, active.
module tb_pwm_fade_multi;

    localparam int CH = 2;
    localparam int LB = 4;
    localparam int FB = 8;
    localparam int FMAX = 255;
    localparam int BPER = 510;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] trigger;
    logic [2*CH-1:0] mode;
    logic [LB-1:0] steady_level;
    logic [CH-1:0] drive;
    logic [CH-1:0] active;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: FADE tracks cycles since trigger, BREATHE tracks phase in period.
    int mq[CH];
    int since[CH];
    int phase[CH];
    int mpwm;
    logic [CH-1:0] mdrive;

    pwm_fade_multi #(
        .CHANNELS   (CH),
        .LEVEL_BITS (LB),
        .FADE_BITS  (FB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trigger      (trigger),
        .mode         (mode),
        .steady_level (steady_level),
        .drive        (drive),
        .active       (active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mfade(int c);
        if (mq[c] == 1) return FMAX - since[c];
        if (mq[c] == 3) return (phase[c] <= FMAX) ? phase[c] : BPER - phase[c];
        return 0;
    endfunction

    function automatic int mlevel(int c);
        if (mq[c] == 2) return int'(steady_level);
        return mfade(c) / 16;
    endfunction

    task automatic model_reset();
        mpwm   = 0;
        mdrive = '0;
        for (int c = 0; c < CH; c++) begin
            mq[c]    = 0;
            since[c] = FMAX;
            phase[c] = 0;
        end
    endtask

    task automatic model_edge();
        int lv;
        for (int c = 0; c < CH; c++) begin
            lv = mlevel(c);
            mdrive[c] = (lv == 15) || (mpwm < lv);
        end
        mpwm = (mpwm + 1) % 16;
        for (int c = 0; c < CH; c++) begin
            int md;
            md = int'(mode[2*c +: 2]);
            if (md != mq[c]) begin
                mq[c]    = md;
                since[c] = FMAX;
                phase[c] = 0;
            end else if (mq[c] == 1) begin
                if (trigger[c]) since[c] = 0;
                else if (since[c] < FMAX) since[c]++;
            end else if (mq[c] == 3) begin
                if (trigger[c]) phase[c] = FMAX;
                else phase[c] = (phase[c] + 1) % BPER;
            end
        end
    endtask

    task automatic check_outs();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("drive%0d", c), 32'(drive[c]), 32'(mdrive[c]));
            chk($sformatf("active%0d", c), 32'(active[c]), 32'(mfade(c) != 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_drive", 32'(drive), 32'(0));
        chk("rst_active", 32'(active), 32'(0));
        @(posedge clk);
        #1;
        check_outs();
        rst_n = 1'b1;
    endtask

    task automatic set_mode(input int c, input int m);
        mode[2*c +: 2] = 2'(m);
    endtask

    task automatic steady_duty(input int lv);
        int hi;
        steady_level = 4'(lv);
        run(2);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            hi += int'(drive[0]);
        end
        chk($sformatf("duty_%0d", lv), 32'(hi), 32'((lv == 15) ? 16 : lv));
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        trigger      = '0;
        mode         = '0;
        steady_level = '0;
        model_reset();
        do_reset();
        run(20);

        // Mid-run reset with modes OFF; pwm phase verified via later duty checks.
        do_reset();
        run(3);

        // FADE single pulse on ch0.
        set_mode(0, 1);
        run(3);
        trigger[0] = 1'b1;
        step();
        trigger[0] = 1'b0;
        chk("trig_active", 32'(active[0]), 32'(1));
        n = 0;
        do begin
            step();
            n++;
        end while (active[0] && n < 400);
        chk("fade_len", 32'(n), 32'(255));
        run(10);

        // Retrigger at fade_cnt = 100, then hold trigger.
        trigger[0] = 1'b1;
        step();
        trigger[0] = 1'b0;
        run(155);
        trigger[0] = 1'b1;
        run(4);
        trigger[0] = 1'b0;
        run(40);

        // STEADY duty.
        set_mode(0, 2);
        set_mode(1, 2);
        steady_duty(0);
        steady_duty(5);
        steady_duty(15);
        steady_duty(int'($urandom_range(1, 14)));

        // BREATHE on ch1, trigger mid-ramp.
        set_mode(1, 3);
        run(1100);
        run(int'($urandom_range(20, 200)));
        trigger[1] = 1'b1;
        step();
        trigger[1] = 1'b0;
        run(300);

        // FADE -> BREATHE with trigger in the same cycle.
        set_mode(0, 1);
        run(2);
        trigger[0] = 1'b1;
        step();
        set_mode(0, 3);
        step();
        trigger[0] = 1'b0;
        chk("mc_active", 32'(active[0]), 32'(0));
        run(40);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 149) == 0) set_mode(c, int'($urandom_range(0, 3)));
                trigger[c] = ($urandom_range(0, 47) == 0);
            end
            if ($urandom_range(0, 63) == 0) steady_level = 4'($urandom_range(0, 15));
            if (i == 1200) do_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
